// File: rtl/rx_ctrl_pkg.sv
// Shared types and helpers for the PSK receive acquisition controller.
// State codes are exported on the state port, so the encoding is fixed.
package rx_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET    = 3'd0,
      ST_SEARCH   = 3'd1,
      ST_LOCK     = 3'd2,
      ST_PREAMBLE = 3'd3,
      ST_SYNC     = 3'd4,
      ST_DATA     = 3'd5
   } state_t;

   localparam int RST_HOLD_DEFAULT = 16;

   // Magnitude of a w-bit signed value; the most negative code folds onto the
   // most positive one so the result always fits back into w-1 bits.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int unsigned w);
      logic [31:0] lim;
      logic [31:0] mag;
      lim = 32'd1 << (w - 1);
      mag = (v < 0) ? 32'(-v) : 32'(v);
      if (mag >= lim) begin
         mag = lim - 32'd1;
      end
      return mag;
   endfunction

endpackage

// File: rtl/rx_lock_detect.sv
// Costas lock detector: counts consecutive in-limit symbols, combinational locked pulse.
// Latency: locked asserts in the cycle of the qualifying ce_sym; no backpressure.
module rx_lock_detect
   import rx_ctrl_pkg::*;
#(
   parameter int ERR_WIDTH = 16
)(
   input  logic                        clk_32M768,
   input  logic                        rst_n_32M768,
   input  logic                        enable,
   input  logic                        ce_sym,
   input  logic signed [ERR_WIDTH-1:0] costas_err,
   input  logic [15:0]                 lock_threshold,
   input  logic [7:0]                  lock_count,
   output logic                        locked
);

   logic [7:0]  lock_cnt;
   logic [31:0] err_mag;
   logic        in_limit;
   logic [8:0]  cnt_inc;
   logic [7:0]  need;

   assign err_mag  = sat_abs(32'(costas_err), ERR_WIDTH);
   assign in_limit = (err_mag <= {16'd0, lock_threshold});
   assign need     = (lock_count == 8'd0) ? 8'd1 : lock_count;
   assign cnt_inc  = {1'b0, lock_cnt} + 9'd1;
   assign locked   = enable && ce_sym && in_limit && (cnt_inc >= {1'b0, need});

   // Held at zero outside LOCK so every entry starts a fresh run.
   always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
      if (!rst_n_32M768) begin
         lock_cnt <= '0;
      end else if (!enable) begin
         lock_cnt <= '0;
      end else if (ce_sym) begin
         if (!in_limit) begin
            lock_cnt <= '0;
         end else if (lock_cnt != 8'hFF) begin
            lock_cnt <= cnt_inc[7:0];
         end
      end
   end

endmodule

// File: rtl/rx_acq_controller.sv
// Receive acquisition/frame sequencer: SEARCH->LOCK->PREAMBLE->SYNC->DATA, loop reset and stats.
// Latency: 1 clk from flag/strobe to registered state and pulses; no backpressure, input stream is observed only.
module rx_acq_controller
   import rx_ctrl_pkg::*;
#(
   parameter int ERR_WIDTH = 16,
   parameter int RST_HOLD  = RST_HOLD_DEFAULT,
   parameter int CNT_WIDTH = 16
)(
   input  logic                        clk_32M768,
   input  logic                        rst_n_32M768,
   input  logic                        ce_sym,
   input  logic                        SD_flag,
   input  logic                        PD_flag,
   input  logic                        BD_flag,
   input  logic signed [ERR_WIDTH-1:0] costas_err,
   input  logic                        data_tvalid,
   input  logic                        data_tlast,
   input  logic [15:0]                 LOCK_THRESHOLD,
   input  logic [7:0]                  LOCK_COUNT,
   input  logic [15:0]                 TIMEOUT,
   output logic                        loop_rst,
   output logic                        rx_enable,
   output logic [2:0]                  state,
   output logic                        frame_done,
   output logic                        frame_err,
   output logic [CNT_WIDTH-1:0]        frame_cnt,
   output logic [7:0]                  fail_cnt
);

   state_t      state_q, state_d;
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic [15:0] tmo_q, tmo_d;
   logic        locked, active, tmo_hit, sig_loss, frame_end;
   logic        frame_done_d, frame_err_d;

   rx_lock_detect #(.ERR_WIDTH(ERR_WIDTH)) u_lock_detect (
      .clk_32M768     (clk_32M768),
      .rst_n_32M768   (rst_n_32M768),
      .enable         (state_q == ST_LOCK),
      .ce_sym         (ce_sym),
      .costas_err     (costas_err),
      .lock_threshold (LOCK_THRESHOLD),
      .lock_count     (LOCK_COUNT),
      .locked         (locked)
   );

   assign active    = state_q inside {ST_LOCK, ST_PREAMBLE, ST_SYNC, ST_DATA};
   assign tmo_hit   = active && (TIMEOUT != 16'd0) && ce_sym &&
                      (({1'b0, tmo_q} + 17'd1) >= {1'b0, TIMEOUT});
   assign sig_loss  = (state_q inside {ST_LOCK, ST_PREAMBLE, ST_SYNC}) && !SD_flag;
   assign frame_end = (state_q == ST_DATA) && data_tvalid && data_tlast;

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = '0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         ST_RESET: begin
            if (hold_cnt_q >= 16'(RST_HOLD - 1)) state_d = ST_SEARCH;
            else                                 hold_cnt_d = hold_cnt_q + 16'd1;
         end
         ST_SEARCH:   if (SD_flag) state_d = ST_LOCK;
         ST_LOCK:     if (locked)  state_d = ST_PREAMBLE;
         ST_PREAMBLE: if (PD_flag) state_d = ST_SYNC;
         ST_SYNC:     if (BD_flag) state_d = ST_DATA;
         ST_DATA:     state_d = ST_DATA;
         default:     state_d = ST_RESET;
      endcase
      // Frame end beats timeout, which beats signal loss, which beats progress.
      if (frame_end) begin
         state_d      = ST_SEARCH;
         frame_done_d = 1'b1;
      end else if (tmo_hit || sig_loss) begin
         state_d     = ST_RESET;
         frame_err_d = 1'b1;
      end

      if (state_d != state_q || !active)                tmo_d = '0;
      else if (state_q == ST_DATA && data_tvalid)       tmo_d = '0;
      else if (ce_sym && tmo_q != 16'hFFFF)             tmo_d = tmo_q + 16'd1;
      else                                              tmo_d = tmo_q;
   end

   always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
      if (!rst_n_32M768) begin
         state_q    <= ST_RESET;
         hold_cnt_q <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         tmo_q      <= tmo_d;
      end
   end

   always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
      if (!rst_n_32M768) begin
         loop_rst   <= 1'b1;
         rx_enable  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frame_cnt  <= '0;
         fail_cnt   <= '0;
      end else begin
         loop_rst   <= (state_d == ST_RESET);
         rx_enable  <= (state_d == ST_DATA);
         frame_done <= frame_done_d;
         frame_err  <= frame_err_d;
         if (frame_done_d && frame_cnt != {CNT_WIDTH{1'b1}}) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
         if (frame_err_d && fail_cnt != 8'hFF)                fail_cnt  <= fail_cnt + 8'd1;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_rx_acq_controller.sv
// Randomized scoreboard bench for rx_acq_controller: expected transitions are queued by
// the stimulus and matched by a negedge monitor against every state change or pulse.
module tb_rx_acq_controller;

   localparam int S_RESET = 0, S_SEARCH = 1, S_LOCK = 2, S_PRE = 3, S_SYNC = 4, S_DATA = 5;
   localparam int HOLD = 16;

   logic               clk_32M768 = 1'b0;
   logic               rst_n_32M768;
   logic               ce_sym, SD_flag, PD_flag, BD_flag;
   logic signed [15:0] costas_err;
   logic               data_tvalid, data_tlast;
   logic [15:0]        LOCK_THRESHOLD;
   logic [7:0]         LOCK_COUNT;
   logic [15:0]        TIMEOUT;
   logic               loop_rst, rx_enable, frame_done, frame_err;
   logic [2:0]         state;
   logic [15:0]        frame_cnt;
   logic [7:0]         fail_cnt;

   rx_acq_controller #(.ERR_WIDTH(16), .RST_HOLD(HOLD), .CNT_WIDTH(16)) dut (
      .clk_32M768(clk_32M768), .rst_n_32M768(rst_n_32M768), .ce_sym(ce_sym),
      .SD_flag(SD_flag), .PD_flag(PD_flag), .BD_flag(BD_flag), .costas_err(costas_err),
      .data_tvalid(data_tvalid), .data_tlast(data_tlast), .LOCK_THRESHOLD(LOCK_THRESHOLD),
      .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT), .loop_rst(loop_rst), .rx_enable(rx_enable),
      .state(state), .frame_done(frame_done), .frame_err(frame_err),
      .frame_cnt(frame_cnt), .fail_cnt(fail_cnt)
   );

   initial forever #5 clk_32M768 = ~clk_32M768;

   typedef struct {
      int st;     // state entered
      int syms;   // ce_sym count in the state left (clk cycles when leaving RESET), -1 = any
      bit done;
      bit err;
      int fcnt;
      int flcnt;
   } exp_t;

   exp_t exp_q[$];
   int   dir_errs[$];
   int   checks = 0;
   int   errors = 0;
   int   m_frame = 0;
   int   m_fail  = 0;

   function automatic void push_exp(input int st, input int syms, input bit done, input bit err);
      exp_t e;
      if (done && m_frame < 65535) m_frame++;
      if (err && m_fail < 255) m_fail++;
      e.st = st; e.syms = syms; e.done = done; e.err = err; e.fcnt = m_frame; e.flcnt = m_fail;
      exp_q.push_back(e);
   endfunction

   function automatic int err_mag(input int e);
      if (e == -32768) return 32767;
      return (e < 0) ? -e : e;
   endfunction

   function automatic int gen_err(input int thr, input int i);
      int r;
      int m;
      r = int'($urandom_range(0, 15));
      if (i >= 40 || r < 11) return int'($urandom_range(0, 2 * thr)) - thr;
      if (r == 15) return -32768;
      m = thr + 1 + int'($urandom_range(0, 20000));
      return r[0] ? -m : m;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk_32M768);
      #1;
   endtask

   task automatic sym_pulse();
      ce_sym = 1'b1;
      step();
      ce_sym = 1'b0;
      repeat ($urandom_range(0, 2)) step();
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         step();
         t++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0 state=%0d", exp_q.size(), state);
         exp_q.delete();
      end
   endtask

   task automatic monitor();
      int   prev_st = S_RESET;
      int   cyc_cnt = 0;
      int   sym_cnt = 0;
      int   meas;
      bit   ok;
      exp_t e;
      forever begin
         @(negedge clk_32M768);
         if (!rst_n_32M768) begin
            prev_st = S_RESET; cyc_cnt = 0; sym_cnt = 0;
         end else begin
            cyc_cnt++;
            if (int'(state) != prev_st || frame_done || frame_err) begin
               checks++;
               meas = (prev_st == S_RESET) ? cyc_cnt : sym_cnt;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_event state=%0d from=%0d done=%b err=%b", state, prev_st, frame_done, frame_err);
               end else begin
                  e = exp_q.pop_front();
                  ok = (int'(state) == e.st) && (e.syms < 0 || meas == e.syms) &&
                       (frame_done == e.done) && (frame_err == e.err) &&
                       (int'(frame_cnt) == e.fcnt) && (int'(fail_cnt) == e.flcnt) &&
                       (loop_rst == (e.st == S_RESET)) && (rx_enable == (e.st == S_DATA));
                  if (!ok) begin
                     errors++;
                     $display("FAIL transition from=%0d actual: st=%0d cnt=%0d done=%b err=%b fcnt=%0d flcnt=%0d lrst=%b rxen=%b required: st=%0d cnt=%0d done=%b err=%b fcnt=%0d flcnt=%0d",
                              prev_st, state, meas, frame_done, frame_err, frame_cnt, fail_cnt, loop_rst, rx_enable,
                              e.st, e.syms, e.done, e.err, e.fcnt, e.flcnt);
                  end
               end
               prev_st = int'(state); cyc_cnt = 0; sym_cnt = 0;
            end
            if (ce_sym) sym_cnt++;
         end
      end
   endtask

   task automatic enter_lock();
      push_exp(S_LOCK, -1, 0, 0);
      SD_flag = 1'b1;
      step();
   endtask

   // Lock point found from the rule: run of in-limit symbols reaching max(LOCK_COUNT,1).
   task automatic do_lock();
      int thr, need, run, idx, e;
      int errs[$];
      thr  = int'(LOCK_THRESHOLD);
      need = (LOCK_COUNT == 8'd0) ? 1 : int'(LOCK_COUNT);
      errs = dir_errs;
      dir_errs.delete();
      run = 0; idx = -1;
      for (int i = 0; idx < 0; i++) begin
         if (i < errs.size()) e = errs[i];
         else begin e = gen_err(thr, i); errs.push_back(e); end
         if (err_mag(e) <= thr) run++; else run = 0;
         if (run >= need) idx = i;
      end
      push_exp(S_PRE, idx + 1, 0, 0);
      for (int i = 0; i <= idx; i++) begin
         costas_err = 16'(errs[i]);
         sym_pulse();
      end
   endtask

   task automatic do_preamble(input int k);
      push_exp(S_SYNC, k, 0, 0);
      repeat (k) sym_pulse();
      PD_flag = 1'b1; step(); PD_flag = 1'b0;
   endtask

   task automatic do_sync(input int k);
      push_exp(S_DATA, k, 0, 0);
      repeat (k) sym_pulse();
      BD_flag = 1'b1; step(); BD_flag = 1'b0;
   endtask

   task automatic do_data(input int n);
      int gaps[$];
      int tot = 0;
      for (int b = 0; b < n; b++) begin
         gaps.push_back(int'($urandom_range(0, 2)));
         tot += gaps[b];
      end
      push_exp(S_SEARCH, tot, 1, 0);
      for (int b = 0; b < n; b++) begin
         repeat (gaps[b]) sym_pulse();
         data_tvalid = 1'b1;
         data_tlast  = (b == n - 1);
         if (b == n - 1) SD_flag = 1'b0;
         step();
         data_tvalid = 1'b0; data_tlast = 1'b0;
      end
   endtask

   task automatic run_frame(input int nbytes);
      enter_lock();
      do_lock();
      do_preamble(int'($urandom_range(0, 4)));
      do_sync(int'($urandom_range(0, 4)));
      do_data(nbytes);
      drain();
   endtask

   task automatic to_data();
      enter_lock();
      do_lock();
      do_preamble(2);
      do_sync(1);
   endtask

   initial begin
      rst_n_32M768 = 1'b0; ce_sym = 0; SD_flag = 0; PD_flag = 0; BD_flag = 0;
      costas_err = '0; data_tvalid = 0; data_tlast = 0;
      LOCK_THRESHOLD = 16'd200; LOCK_COUNT = 8'd4; TIMEOUT = 16'd0;
      fork monitor(); join_none
      repeat (3) @(posedge clk_32M768);
      #1;
      chk("rst_state", int'(state), S_RESET);
      chk("rst_loop_rst", int'(loop_rst), 1);
      chk("rst_rx_enable", int'(rx_enable), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      chk("rst_fail_cnt", int'(fail_cnt), 0);
      push_exp(S_SEARCH, HOLD, 0, 0);
      @(negedge clk_32M768); #1 rst_n_32M768 = 1'b1;
      drain();

      // Happy path with a disturbed lock run, then saturating-abs and threshold edges.
      dir_errs = {100, 100, 300, 100, 100, 100, 100};
      run_frame(10);
      dir_errs = {100, -32768, 100, 100, 100, 100};
      run_frame(3);
      dir_errs = {200, -200, 200, -200};
      run_frame(1);
      dir_errs = {201, 200, 200, 200, 200};
      run_frame(2);
      LOCK_THRESHOLD = 16'd32767; LOCK_COUNT = 8'd3;
      dir_errs = {-32768, -32768, -32768};
      run_frame(4);

      for (int f = 0; f < 25; f++) begin
         LOCK_THRESHOLD = 16'($urandom_range(50, 2000));
         LOCK_COUNT     = 8'($urandom_range(0, 6));
         TIMEOUT        = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(60, 100));
         run_frame(int'($urandom_range(1, 12)));
      end

      // Timeout in PREAMBLE, then full hold again.
      LOCK_THRESHOLD = 16'd500; LOCK_COUNT = 8'd2; TIMEOUT = 16'd8;
      dir_errs = {0, 0};
      enter_lock(); do_lock();
      push_exp(S_RESET, 8, 0, 1); push_exp(S_SEARCH, HOLD, 0, 0);
      repeat (8) sym_pulse();
      SD_flag = 1'b0;
      drain();

      // Frame end coinciding with timeout expiry.
      dir_errs = {0, 0};
      to_data();
      push_exp(S_SEARCH, 8, 1, 0);
      repeat (7) sym_pulse();
      ce_sym = 1; data_tvalid = 1; data_tlast = 1; SD_flag = 0;
      step();
      ce_sym = 0; data_tvalid = 0; data_tlast = 0;
      drain();

      // DATA timeout: a byte restarts the count, SD loss is ignored.
      dir_errs = {0, 0};
      to_data();
      SD_flag = 1'b0;
      push_exp(S_RESET, 11, 0, 1); push_exp(S_SEARCH, HOLD, 0, 0);
      repeat (3) sym_pulse();
      data_tvalid = 1; step(); data_tvalid = 0;
      repeat (8) sym_pulse();
      drain();

      // TIMEOUT=0 never expires; exit by signal loss instead.
      TIMEOUT = 16'd0;
      dir_errs = {0, 0};
      enter_lock(); do_lock();
      push_exp(S_RESET, 20, 0, 1); push_exp(S_SEARCH, HOLD, 0, 0);
      repeat (20) sym_pulse();
      SD_flag = 1'b0; step();
      drain();

      // Signal loss in SYNC.
      dir_errs = {0, 0};
      enter_lock(); do_lock(); do_preamble(1);
      push_exp(S_RESET, 3, 0, 1); push_exp(S_SEARCH, HOLD, 0, 0);
      repeat (3) sym_pulse();
      SD_flag = 1'b0; step();
      drain();

      // Failure counter saturation via immediate loss in LOCK.
      for (int n = 0; n < 300; n++) begin
         push_exp(S_LOCK, -1, 0, 0); push_exp(S_RESET, 0, 0, 1); push_exp(S_SEARCH, HOLD, 0, 0);
         SD_flag = 1'b1; step();
         SD_flag = 1'b0; step();
         repeat (HOLD + 1) step();
         drain();
      end
      chk("fail_cnt_sat", int'(fail_cnt), 255);

      // Async reset in the middle of DATA.
      dir_errs = {0, 0};
      to_data();
      repeat (3) begin data_tvalid = 1; step(); data_tvalid = 0; step(); end
      chk("pre_arst_rx_enable", int'(rx_enable), 1);
      @(posedge clk_32M768); #3 rst_n_32M768 = 1'b0;
      #1;
      chk("arst_state", int'(state), S_RESET);
      chk("arst_rx_enable", int'(rx_enable), 0);
      chk("arst_loop_rst", int'(loop_rst), 1);
      chk("arst_frame_err", int'(frame_err), 0);
      chk("arst_frame_cnt", int'(frame_cnt), 0);
      chk("arst_fail_cnt", int'(fail_cnt), 0);
      m_frame = 0; m_fail = 0;
      SD_flag = 1'b0;
      repeat (2) @(posedge clk_32M768);
      push_exp(S_SEARCH, HOLD, 0, 0);
      @(negedge clk_32M768); #1 rst_n_32M768 = 1'b1;
      drain();
      LOCK_THRESHOLD = 16'd300; LOCK_COUNT = 8'd2;
      run_frame(5);
      chk("final_frame_cnt", int'(frame_cnt), m_frame);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/rx_acq_controller.md
# rx_acq_controller

Acquisition and frame sequencer for the PSK receive chain, clocked at 32.768 MHz. It watches the carrier and timing loops, the signal, preamble and barker detectors, and the depacketizer output stream. It steps the receiver through search, lock, preamble, sync and data phases. On timeout or loss of signal it pulses a datapath reset into the Costas, Gardner and detector blocks, and it exports frame and failure statistics.

## Interface
Parameters:
- ERR_WIDTH, 16, width of the signed Costas phase-error input
- RST_HOLD, 16, number of clk cycles loop_rst is held in RESET (≥1)
- CNT_WIDTH, 16, width of frame_cnt

Ports:
- clk_32M768  in  1  system clock; the block has one clock
- rst_n_32M768  in  1  asynchronous active-low reset
- ce_sym  in  1  one-cycle symbol strobe from the Gardner recovered clock
- SD_flag / PD_flag / BD_flag  in  1 each  signal, preamble and barker detect flags (level)
- costas_err  in  ERR_WIDTH  signed Costas loop error, sampled on ce_sym
- data_tvalid / data_tlast  in  1 each  depacketizer byte stream
- LOCK_THRESHOLD  in  16  unsigned |error| lock limit
- LOCK_COUNT  in  8  consecutive in-limit symbols required for lock; 0 treated as 1
- TIMEOUT  in  16  per-phase symbol timeout; 0 disables timeouts
- loop_rst  out  1  active-high synchronous reset to the Costas, Gardner and detector blocks
- rx_enable  out  1  high in DATA only; gates the depacketizer output downstream
- state  out  3  current state code
- frame_done  out  1  one-cycle pulse on a good frame end
- frame_err  out  1  one-cycle pulse on timeout or signal loss
- frame_cnt  out  CNT_WIDTH  good frames, saturating
- fail_cnt  out  8  failures, saturating

## Operation
- States and codes: RESET=0, SEARCH=1, LOCK=2, PREAMBLE=3, SYNC=4, DATA=5. Codes 6 and 7 are illegal and go to RESET on the next cycle.
- RESET: loop_rst=1. The hold counter counts clk cycles. After RST_HOLD cycles the block goes to SEARCH.
- SEARCH: waits for SD_flag=1, then goes to LOCK. No timeout applies in SEARCH.
- LOCK: evaluated on each ce_sym.
  - |costas_err| ≤ LOCK_THRESHOLD increments lock_cnt; any other value clears lock_cnt.
  - When lock_cnt reaches LOCK_COUNT, go to PREAMBLE.
  - Absolute value saturates: -2^(ERR_WIDTH-1) maps to 2^(ERR_WIDTH-1)-1.
- PREAMBLE: PD_flag=1 goes to SYNC.
- SYNC: BD_flag=1 goes to DATA.
- DATA: data_tvalid & data_tlast raises frame_done, increments frame_cnt, and goes to SEARCH.
- Timeout counter (tmo):
  - Cleared on every state entry, and in DATA on every data_tvalid.
  - Increments on ce_sym in LOCK, PREAMBLE, SYNC and DATA.
  - When TIMEOUT≠0 and tmo reaches TIMEOUT: frame_err, fail_cnt+1, go to RESET.
- Signal loss: SD_flag=0 in LOCK, PREAMBLE or SYNC gives frame_err, fail_cnt+1, and RESET. DATA ignores SD_flag and relies on the timeout.
- Priority when events coincide in one cycle: frame end > timeout > signal loss > forward progress.
- Counters saturate at all-ones and never wrap.
- TIMEOUT and LOCK_COUNT are sampled live; the team's convention is to change them only while in SEARCH.

## Timing
- Reset values:
  - state=RESET
  - loop_rst=1
  - rx_enable=0
  - frame_done=0, frame_err=0
  - frame_cnt=0, fail_cnt=0
  - internal lock_cnt=0, tmo=0, hold counter=0
- After reset release: loop_rst stays high exactly RST_HOLD cycles, and state=SEARCH on cycle RST_HOLD.
- All outputs are registered.
- Latency from an input flag or strobe to the state change is 1 clk.
- frame_done and frame_err assert in the same cycle as the state transition they cause.
- rx_enable=1 from the cycle state becomes DATA until the cycle state leaves it.
- A frame error entering RESET restarts the full RST_HOLD hold.
- Async reset mid-frame forces all reset values immediately, with no pulse on frame_err.

## Structure
- Shared package rx_ctrl_pkg holds:
  - the state enum and codes
  - the default RST_HOLD
  - the saturating-abs function, reused by the lock detectors
- One sub-module is natural: rx_lock_detect, containing the abs, compare and consecutive counter, which outputs a locked pulse.
- The FSM, timeout counter and statistics stay in the top module.

## Test plan
- Reset release with RST_HOLD=16 → loop_rst high 16 cycles, state 0→1, all counters 0.
- Happy path: SD=1; 4 symbols with err=±100 and THRESHOLD=200, LOCK_COUNT=4; then PD; then BD; then 10 bytes with tlast on the 10th → states 1→2→3→4→5→1, frame_done once, frame_cnt=1, fail_cnt=0.
- Lock disturbance: err sequence 100,100,300,100,100,100,100 with LOCK_COUNT=4 → PREAMBLE entered only after the last 4 in-limit symbols; err=-32768 counts as out of limit.
- Timeout: TIMEOUT=8 and no PD in PREAMBLE → after 8 ce_sym, frame_err pulse, fail_cnt=1, loop_rst held 16 cycles again. With TIMEOUT=0 → no exit.
- Coincidence: tlast and the TIMEOUT expiry in the same cycle → frame_done only, frame_cnt+1, fail_cnt unchanged. SD drop in SYNC → frame_err and RESET.
- Saturation and async reset: force 300 failures → fail_cnt=255. Assert rst_n mid-DATA → rx_enable=0 and state=0 immediately.
